// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select FSM (RUN/FLUSH/HALT) with optional return-address stack.
// Ports: clk, reset (async, active-high); pc_in, stall, halt_req, resume, jump,
//   branch, branch_taken, call, ret, target in; next_pc, inst_valid, halted,
//   sp, stack_ovf, stack_unf out. Stack present only with `define PC_SEQ_STACK_EN.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc_in,
  input  logic       stall,
  input  logic       halt_req,
  input  logic       resume,
  input  logic       jump,
  input  logic       branch,
  input  logic       branch_taken,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] target,
  output logic [7:0] next_pc,
  output logic       inst_valid,
  output logic       halted,
  output logic [3:0] sp,
  output logic       stack_ovf,
  output logic       stack_unf
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pc_inc;
  logic       taken;

  logic sel_halt;
  logic sel_ret;
  logic sel_call;
  logic sel_jump;
  logic sel_br;
  logic sel_stall;

  if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_bad_depth
    $error("pc_sequencer: STACK_DEPTH must be 2..8");
  end

  assign pc_inc = pc_in + 8'd1;
  assign taken  = branch & branch_taken;

  // Priority chain flattened to one-hot selects
  assign sel_halt  = halt_req;
  assign sel_ret   = ~halt_req & ret;
  assign sel_call  = ~halt_req & ~ret & call;
  assign sel_jump  = ~halt_req & ~ret & ~call & jump;
  assign sel_br    = ~halt_req & ~ret & ~call & ~jump & taken;
  assign sel_stall = ~halt_req & ~ret & ~call & ~jump
                   & ~taken & stall;

`ifdef PC_SEQ_STACK_EN
  localparam int         IW    = $clog2(STACK_DEPTH);
  localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

  logic [STACK_DEPTH-1:0][7:0] stack;
  logic [3:0] sp_q;
  logic [3:0] sp_dec;
  logic       ovf_q;
  logic       unf_q;
  logic       push;
  logic       pop;
  logic       set_ovf;
  logic       set_unf;
  logic [7:0] top;

  assign sp_dec = sp_q - 4'd1;
  assign top    = stack[sp_dec[IW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack <= '0;
      sp_q  <= 4'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push) begin
        stack[sp_q[IW-1:0]] <= pc_inc;
        sp_q <= sp_q + 4'd1;
      end else if (pop) begin
        sp_q <= sp_dec;
      end
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  assign sp        = 4'd0;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    next_pc   = pc_in;
`ifdef PC_SEQ_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
`endif
    unique case (state)
      RUN: begin
        unique case (1'b1)
          sel_halt: state_nxt = HALT;
          sel_ret: begin
`ifdef PC_SEQ_STACK_EN
            if (sp_q != 4'd0) begin
              next_pc   = top;
              pop       = 1'b1;
              state_nxt = FLUSH;
            end else begin
              next_pc = pc_inc;
              set_unf = 1'b1;
            end
`else
            next_pc = pc_inc;
`endif
          end
          sel_call: begin
            next_pc   = target;
            state_nxt = FLUSH;
`ifdef PC_SEQ_STACK_EN
            // Full stack: still redirect, drop the return address
            if (sp_q < DEPTH) push = 1'b1;
            else              set_ovf = 1'b1;
`endif
          end
          sel_jump, sel_br: begin
            next_pc   = target;
            state_nxt = FLUSH;
          end
          sel_stall: next_pc = pc_in;
          default:   next_pc = pc_inc;
        endcase
      end
      FLUSH: begin
        if (!stall) begin
          next_pc   = pc_inc;
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (resume) state_nxt = FLUSH;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign inst_valid = (state == RUN);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with an external PC register.
// Stack scenarios follow `define PC_SEQ_STACK_EN; otherwise call/ret fallbacks.
module tb_pc_sequencer;

  localparam logic [7:0] C_STALL  = 8'h80;
  localparam logic [7:0] C_HALT   = 8'h40;
  localparam logic [7:0] C_RESUME = 8'h20;
  localparam logic [7:0] C_JUMP   = 8'h10;
  localparam logic [7:0] C_BR     = 8'h08;
  localparam logic [7:0] C_TAKEN  = 8'h04;
  localparam logic [7:0] C_CALL   = 8'h02;
  localparam logic [7:0] C_RET    = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, halt_req, resume, jump;
  logic       branch, branch_taken, call, ret;
  logic [7:0] target;
  logic [7:0] next_pc;
  logic       inst_valid, halted;
  logic [3:0] sp;
  logic       stack_ovf, stack_unf;
  logic [7:0] pc_reg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic [7:0] nx;
    logic       v;
    logic       h;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pc_sequencer #(.STACK_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_reg),
    .stall        (stall),
    .halt_req     (halt_req),
    .resume       (resume),
    .jump         (jump),
    .branch       (branch),
    .branch_taken (branch_taken),
    .call         (call),
    .ret          (ret),
    .target       (target),
    .next_pc      (next_pc),
    .inst_valid   (inst_valid),
    .halted       (halted),
    .sp           (sp),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= 8'h00;
    else       pc_reg <= next_pc;
  end

  task automatic check(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ctrl,
                       input logic [7:0] tgt);
    {stall, halt_req, resume, jump,
     branch, branch_taken, call, ret} = ctrl;
    target = tgt;
  endtask

  task automatic cyc(input string tag,
                     input logic [7:0] ctrl,
                     input logic [7:0] tgt,
                     input logic [7:0] e_pc,
                     input logic [7:0] e_nx,
                     input logic       e_v,
                     input logic       e_h,
                     input logic [3:0] e_sp,
                     input logic       e_ovf,
                     input logic       e_unf);
    drive(ctrl, tgt);
    #1;
    check($sformatf("%s pc", tag), pc_reg, e_pc);
    check($sformatf("%s next_pc", tag), next_pc, e_nx);
    check($sformatf("%s inst_valid", tag),
          {7'd0, inst_valid}, {7'd0, e_v});
    check($sformatf("%s halted", tag),
          {7'd0, halted}, {7'd0, e_h});
    check($sformatf("%s sp", tag), {4'd0, sp}, {4'd0, e_sp});
    check($sformatf("%s ovf", tag),
          {7'd0, stack_ovf}, {7'd0, e_ovf});
    check($sformatf("%s unf", tag),
          {7'd0, stack_unf}, {7'd0, e_unf});
    @(negedge clk);
  endtask

  task automatic rst_check(input string tag);
    drive(8'h00, 8'h00);
    reset = 1'b1;
    #1;
    check($sformatf("%s pc", tag), pc_reg, 8'h00);
    check($sformatf("%s next_pc", tag), next_pc, 8'h01);
    check($sformatf("%s inst_valid", tag),
          {7'd0, inst_valid}, 8'h01);
    check($sformatf("%s halted", tag), {7'd0, halted}, 8'h00);
    check($sformatf("%s sp", tag), {4'd0, sp}, 8'h00);
    check($sformatf("%s ovf", tag), {7'd0, stack_ovf}, 8'h00);
    check($sformatf("%s unf", tag), {7'd0, stack_unf}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [7:0] ctrl,
                     input logic [7:0] tgt,
                     input logic [7:0] pc,
                     input logic [7:0] nx,
                     input logic       v,
                     input logic       h);
    vec_t r;
    r.ctrl = ctrl;
    r.tgt  = tgt;
    r.pc   = pc;
    r.nx   = nx;
    r.v    = v;
    r.h    = h;
    tbl.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(8'h00, 8'h00);

    add(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h02, 8'h03, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h03, 8'h04, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h04, 8'h05, 1'b1, 1'b0);
    add(C_JUMP, 8'h40, 8'h05, 8'h40, 1'b1, 1'b0);
    add(C_JUMP | C_HALT | C_CALL | C_RET | C_RESUME,
        8'h99, 8'h40, 8'h41, 1'b0, 1'b0);
    add(8'h00, 8'h00, 8'h41, 8'h42, 1'b1, 1'b0);
    add(C_STALL, 8'h00, 8'h42, 8'h42, 1'b1, 1'b0);
    add(C_STALL | C_JUMP, 8'h1F, 8'h42, 8'h1F, 1'b1, 1'b0);
    add(C_STALL, 8'h00, 8'h1F, 8'h1F, 1'b0, 1'b0);
    add(8'h00, 8'h00, 8'h1F, 8'h20, 1'b0, 1'b0);
    add(C_HALT, 8'h00, 8'h20, 8'h20, 1'b1, 1'b0);
    add(C_JUMP, 8'h77, 8'h20, 8'h20, 1'b0, 1'b1);
    add(C_RET | C_CALL, 8'h77, 8'h20, 8'h20, 1'b0, 1'b1);
    add(C_STALL | C_BR | C_TAKEN, 8'h77,
        8'h20, 8'h20, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++)
      add(8'h00, 8'h00, 8'h20, 8'h20, 1'b0, 1'b1);
    add(C_RESUME, 8'h00, 8'h20, 8'h20, 1'b0, 1'b1);
    add(8'h00, 8'h00, 8'h20, 8'h21, 1'b0, 1'b0);
    add(C_BR, 8'h55, 8'h21, 8'h22, 1'b1, 1'b0);
    add(C_TAKEN, 8'h55, 8'h22, 8'h23, 1'b1, 1'b0);
    add(C_BR | C_TAKEN, 8'h60, 8'h23, 8'h60, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h60, 8'h61, 1'b0, 1'b0);
    add(8'h00, 8'h00, 8'h61, 8'h62, 1'b1, 1'b0);
    add(C_HALT | C_JUMP, 8'h77, 8'h62, 8'h62, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h62, 8'h62, 1'b0, 1'b1);

    @(negedge clk);
    rst_check("reset");

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("row%0d", i), tbl[i].ctrl, tbl[i].tgt,
          tbl[i].pc, tbl[i].nx, tbl[i].v, tbl[i].h,
          4'd0, 1'b0, 1'b0);

    check("pre-reset halted", {7'd0, halted}, 8'h01);
    rst_check("reset in halt");

    cyc("wrap1", C_JUMP, 8'hFE, 8'h00, 8'hFE, 1, 0, 0, 0, 0);
    cyc("wrap2", 8'h00, 8'h00, 8'hFE, 8'hFF, 0, 0, 0, 0, 0);
    cyc("wrap3", 8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 0);
    cyc("wrap4", 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0, 0);

`ifdef PC_SEQ_STACK_EN
    cyc("s01", C_JUMP, 8'h0F, 8'h01, 8'h0F, 1, 0, 0, 0, 0);
    cyc("s02", 8'h00, 8'h00, 8'h0F, 8'h10, 0, 0, 0, 0, 0);
    cyc("s03", C_CALL, 8'h80, 8'h10, 8'h80, 1, 0, 0, 0, 0);
    cyc("s04", 8'h00, 8'h00, 8'h80, 8'h81, 0, 0, 1, 0, 0);
    cyc("s05", 8'h00, 8'h00, 8'h81, 8'h82, 1, 0, 1, 0, 0);
    cyc("s06", C_RET, 8'h00, 8'h82, 8'h11, 1, 0, 1, 0, 0);
    cyc("s07", 8'h00, 8'h00, 8'h11, 8'h12, 0, 0, 0, 0, 0);
    cyc("s08", C_CALL, 8'h30, 8'h12, 8'h30, 1, 0, 0, 0, 0);
    cyc("s09", 8'h00, 8'h00, 8'h30, 8'h31, 0, 0, 1, 0, 0);
    cyc("s10", C_CALL, 8'h40, 8'h31, 8'h40, 1, 0, 1, 0, 0);
    cyc("s11", 8'h00, 8'h00, 8'h40, 8'h41, 0, 0, 2, 0, 0);
    cyc("s12", C_CALL, 8'h50, 8'h41, 8'h50, 1, 0, 2, 0, 0);
    cyc("s13", 8'h00, 8'h00, 8'h50, 8'h51, 0, 0, 3, 0, 0);
    cyc("s14", C_CALL, 8'h60, 8'h51, 8'h60, 1, 0, 3, 0, 0);
    cyc("s15", 8'h00, 8'h00, 8'h60, 8'h61, 0, 0, 4, 0, 0);
    cyc("s16", C_CALL, 8'h70, 8'h61, 8'h70, 1, 0, 4, 0, 0);
    cyc("s17", 8'h00, 8'h00, 8'h70, 8'h71, 0, 0, 4, 1, 0);
    cyc("s18", C_RET, 8'h00, 8'h71, 8'h52, 1, 0, 4, 1, 0);
    cyc("s19", 8'h00, 8'h00, 8'h52, 8'h53, 0, 0, 3, 1, 0);
    cyc("s20", C_RET, 8'h00, 8'h53, 8'h42, 1, 0, 3, 1, 0);
    cyc("s21", 8'h00, 8'h00, 8'h42, 8'h43, 0, 0, 2, 1, 0);
    cyc("s22", C_RET, 8'h00, 8'h43, 8'h32, 1, 0, 2, 1, 0);
    cyc("s23", 8'h00, 8'h00, 8'h32, 8'h33, 0, 0, 1, 1, 0);
    cyc("s24", C_RET | C_CALL, 8'h99,
        8'h33, 8'h13, 1, 0, 1, 1, 0);
    cyc("s25", 8'h00, 8'h00, 8'h13, 8'h14, 0, 0, 0, 1, 0);
    cyc("s26", C_RET, 8'h00, 8'h14, 8'h15, 1, 0, 0, 1, 0);
    cyc("s27", 8'h00, 8'h00, 8'h15, 8'h16, 1, 0, 0, 1, 1);
    cyc("s28", C_STALL, 8'h00, 8'h16, 8'h16, 1, 0, 0, 1, 1);
`else
    cyc("n1", C_CALL, 8'h80, 8'h01, 8'h80, 1, 0, 0, 0, 0);
    cyc("n2", 8'h00, 8'h00, 8'h80, 8'h81, 0, 0, 0, 0, 0);
    cyc("n3", C_RET, 8'h00, 8'h81, 8'h82, 1, 0, 0, 0, 0);
    cyc("n4", C_RET | C_CALL, 8'h99,
        8'h82, 8'h83, 1, 0, 0, 0, 0);
    cyc("n5", 8'h00, 8'h00, 8'h83, 8'h84, 1, 0, 0, 0, 0);
    cyc("n6", C_RET, 8'h00, 8'h84, 8'h85, 1, 0, 0, 0, 0);
    cyc("n7", 8'h00, 8'h00, 8'h85, 8'h86, 1, 0, 0, 0, 0);
`endif

    rst_check("final reset");
    cyc("post", 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, is the number of return-address stack entries (legal values 2..8).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  8  current PC, taken from the program counter register output.
REQ-005 stall  input  1  hold the PC this cycle.
REQ-006 halt_req  input  1  enter HALT.
REQ-007 resume  input  1  leave HALT.
REQ-008 jump  input  1  unconditional redirect to target.
REQ-009 branch  input  1  conditional redirect; qualified by branch_taken.
REQ-010 branch_taken  input  1  branch condition result.
REQ-011 call  input  1  push return address, then redirect to target.
REQ-012 ret  input  1  pop the stack and redirect to the popped address.
REQ-013 target  input  8  redirect address.
REQ-014 next_pc  output  8  combinational; drives the program counter register input.
REQ-015 inst_valid  output  1  instruction at pc_in is valid; 0 while flushing or halted.
REQ-016 halted  output  1  high in HALT.
REQ-017 sp  output  4  stack occupancy, 0..STACK_DEPTH.
REQ-018 stack_ovf, stack_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-019 The FSM SHALL have three states: RUN, FLUSH and HALT.
REQ-020 In RUN, priority SHALL be: halt_req > ret > call > jump > (branch & branch_taken) > stall > increment.
REQ-021 On increment, next_pc SHALL equal pc_in+1 modulo 256, so 8'hFF wraps to 8'h00.
REQ-022 On stall, or in HALT, next_pc SHALL equal pc_in, and the state, sp and the flags SHALL be unchanged.
REQ-023 A redirect (ret with sp>0, call, jump, or taken branch) SHALL set next_pc to the destination and go to FLUSH on the next edge.
REQ-024 A call SHALL push pc_in+1 (wrapped) when sp<STACK_DEPTH.
REQ-025 A call with sp==STACK_DEPTH SHALL still redirect, SHALL NOT push, and SHALL set stack_ovf.
REQ-026 A ret with sp==0 SHALL increment, stay in RUN and set stack_unf.
REQ-027 A not-taken branch SHALL behave as increment.
REQ-028 In FLUSH, inst_valid SHALL be 0 and all control inputs SHALL be ignored.
REQ-029 In FLUSH, next_pc SHALL be pc_in+1 (pc_in if stall), and the FSM SHALL return to RUN on the next unstalled edge.
REQ-030 halt_req in RUN SHALL hold the PC and enter HALT; inst_valid SHALL be 0 in HALT.
REQ-031 In HALT, only resume SHALL be honoured: it goes to FLUSH, with next_pc = pc_in.
REQ-032 inst_valid SHALL be 1 in RUN only.
REQ-033 stack_ovf and stack_unf SHALL clear only on reset.

Reset
REQ-034 Asserting reset SHALL immediately force state=RUN, sp=0, stack_ovf=0, stack_unf=0, halted=0 and inst_valid=1.
REQ-035 Stack contents SHALL clear to 8'h00 on reset.
REQ-036 Reset mid-FLUSH or mid-HALT SHALL abandon that state without a further redirect.
REQ-037 After reset with pc_in=0, next_pc SHALL be 8'h01.

Configuration
REQ-038 Macro PC_SEQ_STACK_EN defined: the return-address stack and REQ-024..REQ-026 SHALL be present.
REQ-039 Macro PC_SEQ_STACK_EN undefined: call SHALL act as jump, ret SHALL act as increment, and sp, stack_ovf and stack_unf SHALL be tied to 0.

Verification
REQ-040 Reset, then 5 unstalled cycles -> pc sequence 0,1,2,3,4,5 with inst_valid=1 throughout; pc=8'hFF -> next_pc=8'h00.
REQ-041 jump=1, target=8'h40 at pc=8'h05 -> pc=8'h40 with inst_valid=0 for one cycle, then pc=8'h41 with inst_valid=1.
REQ-042 call target=8'h80 at pc=8'h10, then ret at pc=8'h82 -> sp goes 1 then 0 and pc returns to 8'h11, one flush cycle after each redirect.
REQ-043 Five calls with STACK_DEPTH=4 -> sp=4 and stack_ovf=1; then five rets -> fifth ret increments and sets stack_unf=1.
REQ-044 halt_req at pc=8'h20 -> pc held at 8'h20 and halted=1 for 10 cycles; resume -> one flush cycle, then pc=8'h21.
REQ-045 jump and stall together; ret and call together with sp=1; reset asserted in HALT -> jump wins; ret wins; RUN with sp=0 immediately.
